// File: rtl/mfp_7seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Register map, scan states and the register bundle.
package mfp_7seg_pkg;

  localparam logic [1:0] ADDR_EN     = 2'd0;
  localparam logic [1:0] ADDR_VAL_LO = 2'd1;
  localparam logic [1:0] ADDR_VAL_HI = 2'd2;
  localparam logic [1:0] ADDR_DP     = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [7:0]  en;
    logic [15:0] val_hi;
    logic [15:0] val_lo;
    logic [7:0]  dp;
  } disp_regs_t;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mfp_7seg_scan_ctrl_hex.sv
// Hex nibble to active-low seven-segment pattern.
// Output order is {g,f,e,d,c,b,a}.
module mfp_hex_to_7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/mfp_7seg_scan_ctrl.sv
// Eight-digit seven-segment scan scheduler.
// Shadow registers commit to the active set at frame wrap.
module mfp_7seg_scan_ctrl
  import mfp_7seg_pkg::*;
#(
  parameter int DIGIT_CYC = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        frame_pulse
);

  localparam int CNT_MAX = max3(DIGIT_CYC, BLANK_CYC, 2);
  localparam int CW = $clog2(CNT_MAX);
  localparam bit HAS_BLANK = (BLANK_CYC != 0);
  localparam int BLK_END = HAS_BLANK ? BLANK_CYC - 1 : 0;

  localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYC - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLK_END);

  scan_state_e   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic          commit;

  disp_regs_t shadow, active, active_n;

  logic [31:0] vals;
  logic [3:0]  nib;
  logic [6:0]  seg_dec;
  logic        drive_on;
  logic [7:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_d;

  logic unused_wr;
  assign unused_wr = ^wr_data[31:16];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // A zero-length blank still spends the post-reset cycle in BLANK.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    commit  = 1'b0;
    unique case (state)
      ST_BLANK: begin
        if (!HAS_BLANK || cnt == BLK_LAST) begin
          state_n = ST_DRIVE;
          cnt_n   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt == DIG_LAST) begin
          cnt_n   = '0;
          idx_n   = idx + 3'd1;
          commit  = (idx == 3'd7);
          state_n = HAS_BLANK ? ST_BLANK : ST_DRIVE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
    end else if (wr_en) begin
      unique case (wr_addr)
        ADDR_EN:     shadow.en     <= wr_data[7:0];
        ADDR_VAL_LO: shadow.val_lo <= wr_data[15:0];
        ADDR_VAL_HI: shadow.val_hi <= wr_data[15:0];
        ADDR_DP:     shadow.dp     <= wr_data[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= '0;
    end else if (commit) begin
      active <= shadow;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      rd_addr == ADDR_EN:     rd_data[7:0]  = shadow.en;
      rd_addr == ADDR_VAL_LO: rd_data[15:0] = shadow.val_lo;
      rd_addr == ADDR_VAL_HI: rd_data[15:0] = shadow.val_hi;
      rd_addr == ADDR_DP:     rd_data[7:0]  = shadow.dp;
    endcase
  end

  // Outputs are built from next-cycle state so pins align with it.
  assign active_n = commit ? shadow : active;
  assign vals = {active_n.val_hi, active_n.val_lo};
  assign nib = vals[{idx_n, 2'b00} +: 4];

  mfp_hex_to_7seg u_hex (
    .hex (nib),
    .seg (seg_dec)
  );

  assign drive_on = (state_n == ST_DRIVE)
                  && active_n.en[idx_n];

  always_comb begin
    an_d  = 8'hFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (drive_on) begin
      an_d  = ~(8'b1 << idx_n);
      seg_d = seg_dec;
      dp_d  = ~active_n.dp[idx_n];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an          <= 8'hFF;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_pulse <= 1'b0;
    end else begin
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
      frame_pulse <= commit;
    end
  end

endmodule

// File: tb/tb_mfp_7seg_scan_ctrl.sv
// Randomized bench for the seven-segment scan controller.
// Two instances: 2-cycle blank and zero blank, 4-cycle digits.
module tb_mfp_7seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  rd_addr = '0;

  logic [31:0] rd_data, rd_data0;
  logic [6:0]  seg, seg0;
  logic        dp, dp0;
  logic [7:0]  an, an0;
  logic        fp, fp0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mfp_7seg_scan_ctrl #(.DIGIT_CYC(4), .BLANK_CYC(2)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .seg(seg), .dp(dp), .an(an), .frame_pulse(fp)
  );

  mfp_7seg_scan_ctrl #(.DIGIT_CYC(4), .BLANK_CYC(0)) u_dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data0),
    .seg(seg0), .dp(dp0), .an(an0), .frame_pulse(fp0)
  );

  localparam logic [15:0] DARK = {8'hFF, 7'h7F, 1'b1};

  logic [6:0] hex_lut [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference model: t counts edges since the last reset edge.
  int          t = 0;
  logic [7:0]  m_en, m_dp, a2_en, a2_dp, a0_en, a0_dp;
  logic [31:0] m_val, a2_val, a0_val;

  function automatic bit exp_fp(input int tt, input int b);
    if (b == 0) return (tt > 1) && ((tt - 1) % 32 == 0);
    return (tt > 0) && (tt % 48 == 0);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      t = 0;
      m_en = '0; m_dp = '0; m_val = '0;
      a2_en = '0; a2_dp = '0; a2_val = '0;
      a0_en = '0; a0_dp = '0; a0_val = '0;
    end else begin
      t = t + 1;
      if (exp_fp(t, 2)) begin
        a2_en = m_en; a2_dp = m_dp; a2_val = m_val;
      end
      if (exp_fp(t, 0)) begin
        a0_en = m_en; a0_dp = m_dp; a0_val = m_val;
      end
      if (wr_en) begin
        case (wr_addr)
          2'd0: m_en = wr_data[7:0];
          2'd1: m_val[15:0] = wr_data[15:0];
          2'd2: m_val[31:16] = wr_data[15:0];
          default: m_dp = wr_data[7:0];
        endcase
      end
    end
  end

  function automatic logic [15:0] exp_out(
    input int tt, input int b,
    input logic [7:0] en, input logic [31:0] val,
    input logic [7:0] dpv
  );
    int per, p, slot;
    logic [7:0] oh;
    per = b + 4;
    if (b == 0) begin
      if (tt < 1) return DARK;
      p = (tt - 1) % (8 * per);
    end else begin
      p = tt % (8 * per);
    end
    slot = p / per;
    if (p % per < b) return DARK;
    if (!en[slot]) return DARK;
    oh = '0;
    oh[slot] = 1'b1;
    return {~oh, hex_lut[val[slot*4 +: 4]], ~dpv[slot]};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0: return {24'h0, m_en};
      2'd1: return {16'h0, m_val[15:0]};
      2'd2: return {16'h0, m_val[31:16]};
      default: return {24'h0, m_dp};
    endcase
  endfunction

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_readback;
    do_write(2'd0, 32'hDEADBEEF);
    rd_addr = 2'd0; #1;
    total++;
    if (rd_data !== 32'h0000_00EF) begin
      bad++; $display("FAIL rd_en got=%h want=000000ef", rd_data);
    end
    do_write(2'd1, 32'hDEADBEEF);
    rd_addr = 2'd1; #1;
    total++;
    if (rd_data !== 32'h0000_BEEF) begin
      bad++; $display("FAIL rd_lo got=%h want=0000beef", rd_data);
    end
    do_write(2'd3, 32'h1234_56A5);
    rd_addr = 2'd3; #1;
    total++;
    if (rd_data0 !== 32'h0000_00A5) begin
      bad++; $display("FAIL rd_dp got=%h want=000000a5", rd_data0);
    end
  endtask

  task automatic test_full_scan;
    logic [15:0] e2, e0;
    int pulses;
    do_write(2'd0, 32'hFF);
    do_write(2'd1, 32'h3210);
    do_write(2'd2, 32'hFEDC);
    do_write(2'd3, 32'h01);
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      e2 = exp_out(t, 2, a2_en, a2_val, a2_dp);
      e0 = exp_out(t, 0, a0_en, a0_val, a0_dp);
      total += 4;
      if ({an, seg, dp} !== e2) begin
        bad++; $display("FAIL scan t=%0d got=%h want=%h", t, {an, seg, dp}, e2);
      end
      if ({an0, seg0, dp0} !== e0) begin
        bad++; $display("FAIL scan0 t=%0d got=%h want=%h", t, {an0, seg0, dp0}, e0);
      end
      if (fp !== exp_fp(t, 2)) begin
        bad++; $display("FAIL fp t=%0d got=%b want=%b", t, fp, exp_fp(t, 2));
      end
      if (fp0 !== exp_fp(t, 0)) begin
        bad++; $display("FAIL fp0 t=%0d got=%b want=%b", t, fp0, exp_fp(t, 0));
      end
      if (i >= 104 && i < 200 && fp) pulses++;
    end
    total++;
    if (pulses != 2) begin
      bad++; $display("FAIL fp_count got=%0d want=2", pulses);
    end
  endtask

  task automatic test_disabled;
    logic [15:0] e2, e0;
    do_write(2'd0, 32'h0A);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      e2 = exp_out(t, 2, a2_en, a2_val, a2_dp);
      e0 = exp_out(t, 0, a0_en, a0_val, a0_dp);
      total += 4;
      if ({an, seg, dp} !== e2) begin
        bad++; $display("FAIL dis t=%0d got=%h want=%h", t, {an, seg, dp}, e2);
      end
      if ({an0, seg0, dp0} !== e0) begin
        bad++; $display("FAIL dis0 t=%0d got=%h want=%h", t, {an0, seg0, dp0}, e0);
      end
      if (fp !== exp_fp(t, 2)) begin
        bad++; $display("FAIL dis_fp t=%0d got=%b want=%b", t, fp, exp_fp(t, 2));
      end
      if (i >= 100 && !(an inside {8'hFF, 8'hFD, 8'hF7})) begin
        bad++; $display("FAIL dis_an t=%0d got=%h want=ff/fd/f7", t, an);
      end
    end
  endtask

  task automatic test_commit;
    logic [15:0] e2, e0;
    int guard;
    do_write(2'd0, 32'hFF);
    guard = 0;
    while (exp_fp(t + 1, 2) == 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (guard >= 60) begin
      bad++; $display("FAIL commit_sync got=%0d want<60", guard);
    end
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = $urandom;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      wr_en = 1'b0;
      e2 = exp_out(t, 2, a2_en, a2_val, a2_dp);
      e0 = exp_out(t, 0, a0_en, a0_val, a0_dp);
      total += 3;
      if ({an, seg, dp} !== e2) begin
        bad++; $display("FAIL commit t=%0d got=%h want=%h", t, {an, seg, dp}, e2);
      end
      if ({an0, seg0, dp0} !== e0) begin
        bad++; $display("FAIL commit0 t=%0d got=%h want=%h", t, {an0, seg0, dp0}, e0);
      end
      if (fp0 !== exp_fp(t, 0)) begin
        bad++; $display("FAIL commit_fp0 t=%0d got=%b want=%b", t, fp0, exp_fp(t, 0));
      end
      if (i == 20) begin
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = $urandom;
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] e2, e0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      e2 = exp_out(t, 2, a2_en, a2_val, a2_dp);
      e0 = exp_out(t, 0, a0_en, a0_val, a0_dp);
      total += 6;
      if ({an, seg, dp} !== e2) begin
        bad++; $display("FAIL rnd t=%0d got=%h want=%h", t, {an, seg, dp}, e2);
      end
      if ({an0, seg0, dp0} !== e0) begin
        bad++; $display("FAIL rnd0 t=%0d got=%h want=%h", t, {an0, seg0, dp0}, e0);
      end
      if (fp !== exp_fp(t, 2)) begin
        bad++; $display("FAIL rnd_fp t=%0d got=%b want=%b", t, fp, exp_fp(t, 2));
      end
      if (fp0 !== exp_fp(t, 0)) begin
        bad++; $display("FAIL rnd_fp0 t=%0d got=%b want=%b", t, fp0, exp_fp(t, 0));
      end
      if (rd_data !== exp_rd(rd_addr)) begin
        bad++; $display("FAIL rnd_rd a=%0d got=%h want=%h", rd_addr, rd_data, exp_rd(rd_addr));
      end
      if (rd_data0 !== exp_rd(rd_addr)) begin
        bad++; $display("FAIL rnd_rd0 a=%0d got=%h want=%h", rd_addr, rd_data0, exp_rd(rd_addr));
      end
      wr_en = ($urandom_range(0, 7) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = $urandom;
      rd_addr = 2'($urandom_range(0, 3));
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] e2, e0;
    int guard;
    guard = 0;
    while ((t % 6) < 2 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    reset = 1'b1;
    @(negedge clk);
    total += 4;
    if ({an, seg, dp} !== DARK) begin
      bad++; $display("FAIL rst_out got=%h want=%h", {an, seg, dp}, DARK);
    end
    if ({an0, seg0, dp0} !== DARK) begin
      bad++; $display("FAIL rst_out0 got=%h want=%h", {an0, seg0, dp0}, DARK);
    end
    if (fp !== 1'b0 || fp0 !== 1'b0) begin
      bad++; $display("FAIL rst_fp got=%b%b want=00", fp, fp0);
    end
    if (rd_data !== 32'h0) begin
      bad++; $display("FAIL rst_rd got=%h want=0", rd_data);
    end
    for (int a = 1; a < 4; a++) begin
      rd_addr = 2'(a); #1;
      total++;
      if (rd_data !== 32'h0) begin
        bad++; $display("FAIL rst_rd a=%0d got=%h want=0", a, rd_data);
      end
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_write(2'd0, 32'hFF);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      e2 = exp_out(t, 2, a2_en, a2_val, a2_dp);
      e0 = exp_out(t, 0, a0_en, a0_val, a0_dp);
      total += 3;
      if ({an, seg, dp} !== e2) begin
        bad++; $display("FAIL post_rst t=%0d got=%h want=%h", t, {an, seg, dp}, e2);
      end
      if ({an0, seg0, dp0} !== e0) begin
        bad++; $display("FAIL post_rst0 t=%0d got=%h want=%h", t, {an0, seg0, dp0}, e0);
      end
      if (fp !== exp_fp(t, 2)) begin
        bad++; $display("FAIL post_rst_fp t=%0d got=%b want=%b", t, fp, exp_fp(t, 2));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_readback;
    test_full_scan;
    test_disabled;
    test_commit;
    test_random;
    test_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
